// File: rtl/weight_line_fifo.sv
// Weight line prefetch buffer between the SDRAM read controller and the accelerator.
// Prefetches up to DEPTH lines per layer and serves line requests with one-cycle latency.
module weight_line_fifo #(
    parameter int LANES = 16,
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [CNT_W-1:0]                   total_lines,
    output logic                               sdram_rd_req,
    input  logic                               sdram_rd_done,
    input  logic [LANES-1:0][WIDTH-1:0]        sdram_rd_buf,
    input  logic                               acc_rd_req,
    output logic [LANES-1:0][WIDTH-1:0]        acc_rd_buf,
    output logic                               acc_dval,
    output logic [$clog2(DEPTH+1)-1:0]         fill_level,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]            tot_q;
    logic [CNT_W-1:0]            fetched_q;
    logic [CNT_W-1:0]            delivered_q;
    logic                        req_q;
    logic                        discard_q;
    logic                        pending_q;
    logic                        err_q;
    logic                        dval_q;
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [PTR_W-1:0]            rd_ptr_q;
    logic [FILL_W-1:0]           count_q;
    logic [LANES-1:0][WIDTH-1:0] mem [DEPTH];
    logic [LANES-1:0][WIDTH-1:0] buf_q;

    logic in_run;
    logic fifo_empty;
    logic push;
    logic pop;
    logic acc_bad;
    logic acc_ok;
    logic fetch_ok;

    assign in_run     = (state_q == S_RUN);
    assign fifo_empty = (count_q == '0);

    // A done for a request issued before a restart is swallowed, never pushed.
    assign push = sdram_rd_done && req_q && !discard_q && !start;

    assign acc_bad = acc_rd_req && !start &&
                     (!in_run || pending_q || (delivered_q >= tot_q));
    assign acc_ok  = acc_rd_req && !start && !acc_bad;

    // No bypass: a line pushed into an empty FIFO is only visible next cycle.
    assign pop = !start && !fifo_empty && (pending_q || acc_ok);

    // One outstanding request at most, so a free slot now is a slot at its done.
    assign fetch_ok = in_run && !start && !req_q &&
                      (fetched_q < tot_q) && (count_q < FILL_W'(DEPTH));

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (total_lines == '0) ? S_DONE : S_RUN;
        end else if ((state_q == S_RUN) && (delivered_q == tot_q)) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot_q     <= '0;
            fetched_q <= '0;
            req_q     <= 1'b0;
            discard_q <= 1'b0;
        end else if (start) begin
            tot_q     <= total_lines;
            fetched_q <= '0;
            discard_q <= req_q && !sdram_rd_done;
            req_q     <= req_q ? !sdram_rd_done : (total_lines != '0);
        end else begin
            if (push) begin
                fetched_q <= fetched_q + CNT_W'(1);
            end
            if (req_q) begin
                if (sdram_rd_done) begin
                    req_q     <= 1'b0;
                    discard_q <= 1'b0;
                end
            end else if (fetch_ok) begin
                req_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + FILL_W'(push) - FILL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= sdram_rd_buf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= 1'b0;
            delivered_q <= '0;
            err_q       <= 1'b0;
            dval_q      <= 1'b0;
        end else if (start) begin
            pending_q   <= 1'b0;
            delivered_q <= '0;
            err_q       <= 1'b0;
            dval_q      <= 1'b0;
        end else begin
            dval_q <= pop;
            if (pop) begin
                delivered_q <= delivered_q + CNT_W'(1);
                pending_q   <= 1'b0;
            end else if (acc_ok) begin
                pending_q <= 1'b1;
            end
            if (acc_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    // The delivered line survives a restart; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (pop) begin
            buf_q <= mem[rd_ptr_q];
        end
    end

    assign sdram_rd_req = req_q;
    assign acc_dval     = dval_q;
    assign acc_rd_buf   = buf_q;
    assign fill_level   = count_q;
    assign busy         = (state_q == S_RUN);
    assign done         = (state_q == S_DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_weight_line_fifo.sv
// Self-checking bench for weight_line_fifo: table-driven layers, hand-written corner
// sequences and a randomized run, all compared cycle by cycle against a queue-based model.
module tb_weight_line_fifo;

    localparam int LANES = 16;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    typedef logic [LANES-1:0][WIDTH-1:0] line_t;

    typedef struct {
        int tl;
        int lat;
        int period;
        int extra;
        int exp_reqs;
        int exp_fill;
        int exp_dvals;
        int exp_err;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   total_lines = '0;
    logic               sdram_rd_req;
    logic               sdram_rd_done = 1'b0;
    line_t              sdram_rd_buf = '0;
    logic               acc_rd_req = 1'b0;
    line_t              acc_rd_buf;
    logic               acc_dval;
    logic [2:0]         fill_level;
    logic               busy;
    logic               done;
    logic               err;

    weight_line_fifo #(
        .LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .total_lines(total_lines),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_done(sdram_rd_done),
        .sdram_rd_buf(sdram_rd_buf), .acc_rd_req(acc_rd_req),
        .acc_rd_buf(acc_rd_buf), .acc_dval(acc_dval), .fill_level(fill_level),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // SDRAM responder state
    bit sd_auto = 1'b1;
    bit sd_spur = 1'b0;
    int sd_lat = 2;
    int sd_age = 0;
    int sd_seq = 0;

    // Observation counters
    int obs_rises = 0;
    int obs_dvals = 0;
    bit last_req = 1'b0;
    bit chk_data = 1'b0;
    int exp_seq = 0;

    // Reference model: layer bookkeeping with a queue standing in for the buffer
    bit    m_busy, m_done, m_req, m_discard, m_pending, m_err, m_dval;
    int    m_fetched, m_delivered, m_tot;
    line_t m_buf;
    line_t m_q[$];

    function automatic line_t make_line(input int n);
        line_t l;
        for (int i = 0; i < LANES; i++) l[i] = 16'(n * 16 + i);
        return l;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_req = 0; m_discard = 0; m_pending = 0;
        m_err = 0; m_dval = 0; m_fetched = 0; m_delivered = 0; m_tot = 0;
        m_buf = '0;
        m_q.delete();
    endtask

    task automatic model_step(input bit st, input int tl, input bit rdone,
                              input line_t rbuf, input bit areq);
        bit accepted, bad, fetch_now, finish, want;
        if (st) begin
            if (m_req) begin
                m_discard = !rdone;
                m_req     = !rdone;
            end else begin
                m_discard = 0;
                m_req     = (tl != 0);
            end
            m_q.delete();
            m_pending = 0; m_err = 0; m_fetched = 0; m_delivered = 0;
            m_tot = tl; m_busy = (tl != 0); m_done = (tl == 0); m_dval = 0;
        end else begin
            accepted  = rdone && m_req && !m_discard;
            bad       = areq && (!m_busy || m_pending || (m_delivered >= m_tot));
            fetch_now = !m_req && m_busy && (m_fetched < m_tot) && (m_q.size() < DEPTH);
            finish    = m_busy && (m_delivered == m_tot);
            want      = m_pending || (areq && !bad);
            if (bad) m_err = 1;
            m_dval = 0;
            if (want && m_q.size() > 0) begin
                m_buf = m_q.pop_front();
                m_dval = 1;
                m_delivered++;
                m_pending = 0;
            end else if (want) begin
                m_pending = 1;
            end
            if (accepted) begin
                m_q.push_back(rbuf);
                m_fetched++;
            end
            if (m_req) begin
                if (rdone) begin
                    m_req = 0;
                    m_discard = 0;
                end
            end else if (fetch_now) begin
                m_req = 1;
            end
            if (finish) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic check_output();
        check("sdram_rd_req", 256'(sdram_rd_req), 256'(m_req));
        check("acc_dval",     256'(acc_dval),     256'(m_dval));
        check("acc_rd_buf",   acc_rd_buf,         m_buf);
        check("fill_level",   256'(fill_level),   256'(m_q.size()));
        check("busy",         256'(busy),         256'(m_busy));
        check("done",         256'(done),         256'(m_done));
        check("err",          256'(err),          256'(m_err));
    endtask

    task automatic sdram_respond();
        if (!sd_auto) return;
        sdram_rd_done = 1'b0;
        if (sdram_rd_req) begin
            if (sd_age >= sd_lat) begin
                sdram_rd_done = 1'b1;
                sdram_rd_buf  = make_line(sd_seq);
                sd_seq++;
                sd_age = 0;
            end else begin
                sd_age++;
            end
        end else begin
            sd_age = 0;
            if (sd_spur && ($urandom_range(0, 15) == 0)) begin
                sdram_rd_done = 1'b1;
                sdram_rd_buf  = make_line(3000 + int'($urandom_range(0, 99)));
            end
        end
    endtask

    task automatic tick();
        sdram_respond();
        model_step(start, int'(total_lines), sdram_rd_done, sdram_rd_buf, acc_rd_req);
        @(posedge clk);
        #1;
        cyc++;
        check_output();
        if (sdram_rd_req && !last_req) obs_rises++;
        last_req = sdram_rd_req;
        if (acc_dval) begin
            obs_dvals++;
            if (chk_data) begin
                check("line_order", acc_rd_buf, make_line(exp_seq));
                exp_seq++;
            end
        end
        start = 1'b0;
        acc_rd_req = 1'b0;
        if (!sd_auto) sdram_rd_done = 1'b0;
    endtask

    task automatic apply_stimulus(input bit st, input int tl, input bit areq);
        start = st;
        total_lines = 16'(tl);
        acc_rd_req = areq;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        acc_rd_req = 1'b0;
        sdram_rd_done = 1'b0;
        sd_age = 0;
        model_reset();
        #1;
        check_output();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        last_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   base;
        bit   found;
        bit   st;
        bit   areq;
        int   tl;

        vecs[0] = '{6, 2, 3, 0, 4, 4, 6, 0};
        vecs[1] = '{6, 2, 3, 1, 4, 4, 6, 1};
        vecs[2] = '{0, 2, 3, 0, 0, 0, 0, 0};
        vecs[3] = '{1, 1, 2, 0, 1, 1, 1, 0};
        vecs[4] = '{3, 4, 1, 0, 3, 3, 3, 0};
        vecs[5] = '{9, 0, 2, 0, 4, 4, 9, 0};
        vecs[6] = '{4, 3, 5, 0, 4, 4, 4, 0};

        do_reset();

        // Whole layers: prefetch with no demand, then drain at a fixed request period
        for (int v = 0; v < 7; v++) begin
            sd_auto = 1'b1; sd_spur = 1'b0; sd_lat = vecs[v].lat; sd_age = 0;
            exp_seq = sd_seq; chk_data = 1'b1;
            obs_rises = 0; obs_dvals = 0; last_req = sdram_rd_req;
            apply_stimulus(1'b1, vecs[v].tl, 1'b0);
            idle(40);
            check("prefetch_reqs", 256'(obs_rises), 256'(vecs[v].exp_reqs));
            check("prefetch_fill", 256'(fill_level), 256'(vecs[v].exp_fill));
            check("prefetch_req_low", 256'(sdram_rd_req), 256'(0));
            for (int k = 0; k < vecs[v].tl + vecs[v].extra; k++) begin
                apply_stimulus(1'b0, 0, 1'b1);
                idle(vecs[v].period - 1);
            end
            idle(20);
            check("layer_dvals", 256'(obs_dvals), 256'(vecs[v].exp_dvals));
            check("layer_done", 256'(done), 256'(1));
            check("layer_busy", 256'(busy), 256'(0));
            check("layer_err", 256'(err), 256'(vecs[v].exp_err));
        end

        // Pended request on an empty FIFO, with a second request dropped as an error
        do_reset();
        sd_auto = 1'b0; chk_data = 1'b1; exp_seq = sd_seq;
        apply_stimulus(1'b1, 1, 1'b0);
        for (int c = 1; c <= 17; c++) begin
            if (c == 14) begin
                sdram_rd_done = 1'b1;
                sdram_rd_buf  = make_line(sd_seq);
                sd_seq++;
            end
            apply_stimulus(1'b0, 0, (c == 10) || (c == 12));
            if (c == 11) check("pend_err_before", 256'(err), 256'(0));
            if (c == 12) check("pend_err_set", 256'(err), 256'(1));
            if (c == 13) check("pend_req_held", 256'(sdram_rd_req), 256'(1));
            if (c == 14) check("pend_req_drop", 256'(sdram_rd_req), 256'(0));
            if (c == 14) check("pend_no_bypass", 256'(acc_dval), 256'(0));
            if (c == 14) check("pend_fill", 256'(fill_level), 256'(1));
            if (c == 15) check("pend_dval", 256'(acc_dval), 256'(1));
            if (c == 16) check("pend_layer_done", 256'(done), 256'(1));
        end

        // Restart the cycle after a request is issued: its done must be discarded
        do_reset();
        sd_auto = 1'b1; sd_spur = 1'b0; sd_lat = 2; chk_data = 1'b1;
        apply_stimulus(1'b1, 3, 1'b0);
        check("rs_first_req", 256'(sdram_rd_req), 256'(1));
        apply_stimulus(1'b0, 0, 1'b0);
        base = sd_seq;
        exp_seq = base + 1;
        apply_stimulus(1'b1, 2, 1'b0);
        check("rs_req_outstanding", 256'(sdram_rd_req), 256'(1));
        apply_stimulus(1'b0, 0, 1'b0);
        check("rs_discard_fill", 256'(fill_level), 256'(0));
        apply_stimulus(1'b0, 0, 1'b0);
        check("rs_discard_fill2", 256'(fill_level), 256'(0));
        idle(12);
        check("rs_refill", 256'(fill_level), 256'(2));
        obs_dvals = 0;
        apply_stimulus(1'b0, 0, 1'b1);
        apply_stimulus(1'b0, 0, 1'b1);
        idle(2);
        check("rs_dvals", 256'(obs_dvals), 256'(2));
        check("rs_done", 256'(done), 256'(1));
        check("rs_err", 256'(err), 256'(0));

        // Asynchronous reset mid-layer, then a fresh one-line layer
        do_reset();
        sd_auto = 1'b1; sd_spur = 1'b0; sd_lat = 2; chk_data = 1'b0;
        apply_stimulus(1'b1, 6, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            apply_stimulus(1'b0, 0, 1'b0);
            if (fill_level == 3'd3 && sdram_rd_req) found = 1'b1;
        end
        check("wait_fill3_req", 256'(found), 256'(1));
        do_reset();
        check("async_fill", 256'(fill_level), 256'(0));
        check("async_req", 256'(sdram_rd_req), 256'(0));
        chk_data = 1'b1; exp_seq = sd_seq;
        apply_stimulus(1'b1, 1, 1'b0);
        check("fresh_busy", 256'(busy), 256'(1));
        check("fresh_req", 256'(sdram_rd_req), 256'(1));
        idle(6);
        check("fresh_fill", 256'(fill_level), 256'(1));
        apply_stimulus(1'b0, 0, 1'b1);
        check("fresh_dval", 256'(acc_dval), 256'(1));
        apply_stimulus(1'b0, 0, 1'b0);
        check("fresh_done", 256'(done), 256'(1));
        check("fresh_err", 256'(err), 256'(0));

        // Randomized layers, restarts, stray dones and excess requests
        sd_auto = 1'b1; sd_spur = 1'b1; chk_data = 1'b0;
        for (int k = 0; k < 2500; k++) begin
            st = ($urandom_range(0, 99) == 0) || (!m_busy && ($urandom_range(0, 9) == 0));
            tl = int'($urandom_range(0, 8));
            areq = ($urandom_range(0, 2) == 0);
            if (st) sd_lat = int'($urandom_range(0, 4));
            apply_stimulus(st, tl, areq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_line_fifo.md
# weight_line_fifo

Parametrised SDRAM-to-accelerator weight line prefetch buffer. It sits between the SDRAM read controller and the accelerator's weight input (`SDRAM_FIFO_in`/`DVAL`/`SRAM_RdReq` path) and replaces the single-line, unbuffered fetch. The block prefetches up to DEPTH lines of LANES×WIDTH weights for a layer of programmable length and serves the accelerator's line requests with fixed one-cycle latency. It also detects underrun and over-request errors.

## Interface
Parameters:
- LANES, 16, weights per line
- WIDTH, 16, bits per weight
- DEPTH, 4, line entries (power of two, ≥2)
- CNT_W, 16, width of line counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- start  in  1  one-cycle pulse; latches total_lines, flushes, begins layer
- total_lines  in  CNT_W  lines in this layer, sampled on start
- sdram_rd_req  out  1  level request for one line
- sdram_rd_done  in  1  one-cycle pulse, sdram_rd_buf valid
- sdram_rd_buf  in  [LANES-1:0][WIDTH-1:0]  returned line
- acc_rd_req  in  1  one-cycle pulse, accelerator wants next line
- acc_rd_buf  out  [LANES-1:0][WIDTH-1:0]  delivered line, registered
- acc_dval  out  1  one-cycle pulse, acc_rd_buf valid
- fill_level  out  $clog2(DEPTH+1)  stored entries
- busy  out  1  layer in progress
- done  out  1  all total_lines delivered; held until next start
- err  out  1  sticky: underrun double-request or over-request; cleared by start

## Operation
- Reset: every output 0, acc_rd_buf 0, state IDLE, counters 0, FIFO empty.
- States:
  - IDLE → RUN on start with total_lines>0.
  - IDLE → DONE on start with total_lines=0.
  - RUN → DONE when the delivered count reaches total_lines.
  - Any state → RUN or DONE on start (restart).
- busy=1 only in RUN. done=1 only in DONE.
- Counters:
  - fetched increments on each accepted sdram_rd_done.
  - delivered increments on each acc_dval.
  - Both are CNT_W bits and never wrap, because requests stop at total_lines.
- Fetch rule: in RUN, assert sdram_rd_req when fetched<total_lines, no request is outstanding, and fill_level<DEPTH. At most one request is outstanding.
- Request handshake:
  - sdram_rd_req stays high until sdram_rd_done, then drops the next cycle.
  - There is at least one low cycle between requests.
  - sdram_rd_done with no outstanding request is ignored.
- Push: an accepted done writes sdram_rd_buf to the tail. The space reservation makes overflow impossible.
- Pop:
  - acc_rd_req with FIFO non-empty: head goes to acc_rd_buf and acc_dval pulses.
  - acc_rd_req with FIFO empty: the request is pended; only one can be pended.
  - A pended request is served in the first cycle the FIFO is non-empty.
  - A second acc_rd_req while one is pended is dropped and sets err.
  - acc_rd_req when delivered+pending=total_lines, or outside RUN, is dropped and sets err.
- Simultaneous push and pop: both take effect and fill_level is unchanged. With the FIFO empty, the pushed line is not bypassed; it is popped the following cycle.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Restart (start while RUN):
  - FIFO, pending request, counters and err are cleared.
  - If a request is outstanding, sdram_rd_req stays high until its done. That done is discarded and does not push.
  - New-layer fetching begins after the discarded done.
- acc_rd_buf holds its last value between pulses and is not cleared by start.

## Timing
- start at cycle 0: busy=1 at cycle 1; sdram_rd_req=1 at cycle 1 (no outstanding request case).
- sdram_rd_done at cycle k: fill_level increments at k+1; sdram_rd_req=0 at k+1; next request no earlier than k+2.
- acc_rd_req at cycle t with FIFO non-empty: acc_dval=1 and acc_rd_buf valid at t+1; fill_level decrements at t+1.
- Pended request, done at cycle k: acc_dval at k+2.
- Last delivery acc_dval at cycle d: done=1 and busy=0 at d+1.
- total_lines=0 start at cycle 0: done=1 at cycle 1; no sdram_rd_req ever asserted.
- rst_n low in any cycle forces reset values immediately, including mid-request and mid-layer.

## Test plan
- DEPTH=4, total_lines=6, SDRAM done 2 cycles after each request, no acc requests: exactly 4 requests issued; fill_level=4; sdram_rd_req stays 0.
- Continue the above with acc_rd_req every 3 cycles: 6 acc_dval pulses with lines in SDRAM order (lane i of line n = 16'(n*16+i)); done=1 the cycle after the 6th acc_dval; err=0.
- Empty FIFO, acc_rd_req at cycle 10, done at cycle 14: acc_dval at 16; second acc_rd_req at 12 sets err=1 and is dropped.
- Restart at the cycle after a request is issued, total_lines=2: the outstanding done is discarded (fill_level stays 0); the next 2 delivered lines are the post-restart data.
- start with total_lines=0: done=1 next cycle, no sdram_rd_req, busy=0; a 7th acc_rd_req after a 6-line layer sets err.
- rst_n pulsed low while fill_level=3 and sdram_rd_req=1: all outputs 0 asynchronously; a subsequent start with total_lines=1 behaves as a fresh layer.
